// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared types and constants for the MEM-stage memory access controller.
//   - mem_state_t : access FSM states (IDLE, BUSY, DONE)
//   - AW_DEF/DW_DEF : default address/data widths
//   - ALIGN_MASK  : low address bits that must be zero for a word access
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned AW_DEF = 32;
    localparam int unsigned DW_DEF = 32;

    // Word accesses only: both byte-offset bits must be clear.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl
//   MEM-stage data-memory access controller. Turns MemRead/MemWrite from
//   EX/MEM into a req/ack transaction to a variable-latency data memory,
//   stalls the pipeline until the transaction completes, and holds load
//   data for MEM/WB.
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous active-low reset
//   MemRead_i    in   load in MEM stage
//   MemWrite_i   in   store in MEM stage
//   Addr_i       in   byte address (AW)
//   WData_i      in   store data (DW)
//   Data_o       out  load data to MEM/WB (DW), held until next completed load
//   stall_o      out  hold upstream stages, bubble into MEM/WB
//   err_o        out  one-cycle pulse: misaligned, read+write conflict, timeout
//   mem_req_o    out  memory request, held until ack (or timeout)
//   mem_we_o     out  1 = write, 0 = read
//   mem_addr_o   out  word-aligned address (AW)
//   mem_wdata_o  out  write data (DW)
//   mem_ack_i    in   one-cycle completion strobe
//   mem_rdata_i  in   read data, valid with mem_ack_i (DW)
// ----------------------------------------------------------------------------
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          MemRead_i,
    input  logic          MemWrite_i,
    input  logic [AW-1:0] Addr_i,
    input  logic [DW-1:0] WData_i,
    output logic [DW-1:0] Data_o,
    output logic          stall_o,
    output logic          err_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i
);

    // Counter is kept at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int unsigned   CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    mem_state_t    r_state;
    mem_state_t    w_next_state;

    logic [DW-1:0] r_data;
    logic          r_err;
    logic          r_req;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [CW-1:0] r_cnt;

    logic          w_access;
    logic          w_aligned;
    logic          w_conflict;
    logic          w_timeout;

    assign w_access   = MemRead_i | MemWrite_i;
    assign w_aligned  = ((Addr_i[1:0] & ALIGN_MASK) == 2'b00);
    assign w_conflict = MemRead_i & MemWrite_i;
    assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and stall
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        stall_o      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_access && w_aligned) begin
                    w_next_state = BUSY;
                    stall_o      = 1'b1;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (mem_ack_i || w_timeout) begin
                    w_next_state = DONE;
                end
            end
            // The pipeline advances at the end of DONE; its inputs still
            // belong to the finished instruction and must not re-issue.
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request, data, error and wait-counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_data  <= '0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_access) begin
                        if (w_aligned) begin
                            // Read+write conflict resolves to a write.
                            r_req   <= 1'b1;
                            r_we    <= MemWrite_i;
                            r_addr  <= {Addr_i[AW-1:2], 2'b00};
                            r_wdata <= WData_i;
                            r_cnt   <= '0;
                        end
                        r_err <= ~w_aligned | w_conflict;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_data <= mem_rdata_i;
                        end
                    end else if (w_timeout) begin
                        r_req <= 1'b0;
                        r_err <= 1'b1;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Data_o      = r_data;
    assign err_o       = r_err;
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl (TIMEOUT=4). Inputs change just after
//   the falling edge; outputs are compared 1 ns later, well before the next
//   rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] Addr_i;
    logic [31:0] WData_i;
    logic [31:0] Data_o;
    logic        stall_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int checks;
    int failures;

    mem_access_ctrl #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .Addr_i      (Addr_i),
        .WData_i     (WData_i),
        .Data_o      (Data_o),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_i       = 1'b0;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        Addr_i      = '0;
        WData_i     = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;

        // Reset state
        cyc(); #1;
        check("rst_req",   mem_req_o,   0);
        check("rst_we",    mem_we_o,    0);
        check("rst_addr",  mem_addr_o,  0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_data",  Data_o,      0);
        check("rst_err",   err_o,       0);
        check("rst_stall", stall_o,     0);
        cyc(); rst_i = 1'b1;

        // 1: load 0x40, ack in third BUSY cycle -> four stall cycles
        cyc(); MemRead_i = 1'b1; Addr_i = 32'h40; #1;
        check("t1_stall_idle", stall_o,   1);
        check("t1_req_idle",   mem_req_o, 0);
        cyc(); #1;
        check("t1_req_b1",   mem_req_o,  1);
        check("t1_we_b1",    mem_we_o,   0);
        check("t1_addr_b1",  mem_addr_o, 32'h40);
        check("t1_stall_b1", stall_o,    1);
        cyc(); #1;
        check("t1_req_b2",   mem_req_o, 1);
        check("t1_stall_b2", stall_o,   1);
        cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; #1;
        check("t1_stall_b3", stall_o,   1);
        check("t1_req_b3",   mem_req_o, 1);
        cyc(); mem_ack_i = 1'b0; mem_rdata_i = '0; #1;
        check("t1_data_done",  Data_o,    32'hDEADBEEF);
        check("t1_req_done",   mem_req_o, 0);
        check("t1_stall_done", stall_o,   0);
        cyc(); MemRead_i = 1'b0; Addr_i = '0; #1;
        check("t1_req_idle2",   mem_req_o, 0);
        check("t1_stall_idle2", stall_o,   0);

        // 2: store 0x80, ack in first BUSY cycle -> two stall cycles
        cyc(); MemWrite_i = 1'b1; Addr_i = 32'h80; WData_i = 32'h1234; #1;
        check("t2_stall_idle", stall_o, 1);
        cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D; #1;
        check("t2_req_b1",   mem_req_o,   1);
        check("t2_we_b1",    mem_we_o,    1);
        check("t2_addr_b1",  mem_addr_o,  32'h80);
        check("t2_wdata_b1", mem_wdata_o, 32'h1234);
        check("t2_stall_b1", stall_o,     1);
        cyc(); mem_ack_i = 1'b0; mem_rdata_i = '0; #1;
        check("t2_stall_done", stall_o,   0);
        check("t2_req_done",   mem_req_o, 0);
        check("t2_data_kept",  Data_o,    32'hDEADBEEF);
        cyc(); MemWrite_i = 1'b0; WData_i = '0; Addr_i = '0;

        // 3: misaligned load 0x42 -> no request, no stall, one err pulse
        cyc(); MemRead_i = 1'b1; Addr_i = 32'h42; #1;
        check("t3_stall", stall_o,   0);
        check("t3_req",   mem_req_o, 0);
        check("t3_err0",  err_o,     0);
        cyc(); MemRead_i = 1'b0; Addr_i = '0; #1;
        check("t3_err1",   err_o,     1);
        check("t3_req1",   mem_req_o, 0);
        check("t3_stall1", stall_o,   0);
        cyc(); #1;
        check("t3_err2", err_o, 0);

        // 4: no ack, TIMEOUT=4 -> request held four BUSY cycles, then abort
        cyc(); MemRead_i = 1'b1; Addr_i = 32'h100; #1;
        check("t4_stall_idle", stall_o, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            check($sformatf("t4_req_b%0d", i + 1),   mem_req_o, 1);
            check($sformatf("t4_stall_b%0d", i + 1), stall_o,   1);
            check($sformatf("t4_err_b%0d", i + 1),   err_o,     0);
        end
        cyc(); #1;
        check("t4_err_done",   err_o,     1);
        check("t4_req_done",   mem_req_o, 0);
        check("t4_stall_done", stall_o,   0);
        check("t4_data_kept",  Data_o,    32'hDEADBEEF);
        cyc(); MemRead_i = 1'b0; Addr_i = '0; #1;
        check("t4_err_idle",   err_o,     0);
        check("t4_req_idle",   mem_req_o, 0);
        check("t4_stall_idle2", stall_o,  0);

        // 5: reset while BUSY clears outputs at once; a late ack is ignored
        cyc(); MemRead_i = 1'b1; Addr_i = 32'h200;
        cyc(); #1;
        check("t5_req_busy", mem_req_o, 1);
        rst_i = 1'b0; #1;
        check("t5_req_rst",   mem_req_o, 0);
        check("t5_data_rst",  Data_o,    0);
        check("t5_stall_rst", stall_o,   1);
        MemRead_i = 1'b0; Addr_i = '0; #1;
        check("t5_stall_rst_noacc", stall_o, 0);
        cyc(); rst_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
        cyc(); mem_ack_i = 1'b0; mem_rdata_i = '0; #1;
        check("t5_data_late", Data_o,    0);
        check("t5_req_late",  mem_req_o, 0);
        check("t5_stall_late", stall_o,  0);

        // 6: back-to-back loads 0x0 then 0x4, no re-issue in DONE
        cyc(); MemRead_i = 1'b1; Addr_i = 32'h0; #1;
        check("t6_stall_idle_a", stall_o, 1);
        cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111; #1;
        check("t6_req_a",  mem_req_o,  1);
        check("t6_addr_a", mem_addr_o, 32'h0);
        cyc(); mem_ack_i = 1'b0; mem_rdata_i = '0; Addr_i = 32'h4; #1;
        check("t6_req_done_a",   mem_req_o, 0);
        check("t6_data_a",       Data_o,    32'h11111111);
        check("t6_stall_done_a", stall_o,   0);
        cyc(); #1;
        check("t6_req_idle_b",   mem_req_o, 0);
        check("t6_stall_idle_b", stall_o,   1);
        cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'h22222222; #1;
        check("t6_req_b",  mem_req_o,  1);
        check("t6_addr_b", mem_addr_o, 32'h4);
        check("t6_we_b",   mem_we_o,   0);
        cyc(); mem_ack_i = 1'b0; mem_rdata_i = '0; #1;
        check("t6_data_b",     Data_o,    32'h22222222);
        check("t6_req_done_b", mem_req_o, 0);
        cyc(); MemRead_i = 1'b0; Addr_i = '0;

        // 7: read and write both high -> treated as write, err pulses
        cyc(); MemRead_i = 1'b1; MemWrite_i = 1'b1; Addr_i = 32'h300; WData_i = 32'hABCD; #1;
        check("t7_stall_idle", stall_o, 1);
        check("t7_err_idle",   err_o,   0);
        cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999; #1;
        check("t7_req",   mem_req_o,   1);
        check("t7_we",    mem_we_o,    1);
        check("t7_err",   err_o,       1);
        check("t7_addr",  mem_addr_o,  32'h300);
        check("t7_wdata", mem_wdata_o, 32'hABCD);
        cyc(); mem_ack_i = 1'b0; mem_rdata_i = '0; MemRead_i = 1'b0; MemWrite_i = 1'b0; #1;
        check("t7_err_done",  err_o,     0);
        check("t7_req_done",  mem_req_o, 0);
        check("t7_data_kept", Data_o,    32'h22222222);

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
